// File: rtl/inst_mem_pkg.sv
// inst_mem_pkg: shared types and defaults for the loadable instruction memory.
// Optional parity protection is selected with the INST_MEM_PARITY_EN macro.
package inst_mem_pkg;

  // Controller states: waiting for a program, accepting words, serving fetches.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam int DEFAULT_A = 10;
  localparam int DEFAULT_W = 9;

endpackage

// File: rtl/inst_mem_array.sv
// inst_mem_array: single-port synchronous RAM with write enable and a
// registered read port. The read data register updates only when a read is
// requested, so the last response is held between fetches.
module inst_mem_array #(
  parameter int A  = 10,
  parameter int DW = 9
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_we,
  input  logic          i_re,
  input  logic [A-1:0]  i_addr,
  input  logic [DW-1:0] i_wdata,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [2**A];
  logic [DW-1:0] r_rdata;

  // Storage write; contents are deliberately never reset.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  // Registered read; the output register clears on reset so the first
  // visible response value is zero.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/inst_mem.sv
// inst_mem: loadable instruction memory for the 9-bit processor.
// A handshake port fills the array, then fetches are served with a one-cycle
// registered read; addresses at or beyond the loaded count return HALT_WORD.
// Define INST_MEM_PARITY_EN to store and check an even parity bit per word.
module inst_mem
  import inst_mem_pkg::*;
#(
  parameter int A = DEFAULT_A,
  parameter int W = DEFAULT_W
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         LoadStart,
  input  logic         LoadValid,
  input  logic         LoadLast,
  input  logic [W-1:0] LoadData,
`ifdef INST_MEM_PARITY_EN
  input  logic         ParityInject,
`endif
  output logic         LoadReady,
  output logic         LoadDone,
  output logic [A:0]   LoadCount,
  input  logic         FetchReq,
  input  logic [A-1:0] InstAddress,
  output logic [W-1:0] InstOut,
  output logic         InstValid,
  output logic         ParityErr
);

  localparam logic [W-1:0] HALT_WORD = '1;
  localparam logic [A:0]   LAST_ADDR = (A+1)'((1 << A) - 1);

`ifdef INST_MEM_PARITY_EN
  localparam int DW = W + 1;
`else
  localparam int DW = W;
`endif

  state_t        r_state;
  state_t        w_state_next;
  logic [A:0]    r_count;
  logic [A:0]    w_count_next;
  logic          w_we;
  logic          w_re;
  logic          r_valid;
  logic          r_in_range;
  logic [A-1:0]  w_addr;
  logic [DW-1:0] w_wdata;
  logic [DW-1:0] w_rdata;

  // State and program-length registers.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_state <= IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
    end
  end

  // Next-state logic; LoadStart always wins over a coincident write or fetch.
  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    w_we         = 1'b0;
    w_re         = 1'b0;
    case (r_state)
      IDLE: begin
        if (LoadStart) begin
          w_state_next = LOAD;
          w_count_next = '0;
        end
      end
      LOAD: begin
        if (LoadStart) begin
          w_count_next = '0;
        end else if (LoadValid) begin
          w_we         = 1'b1;
          w_count_next = r_count + 1'b1;
          // The write to the last array slot ends the load even without LoadLast.
          if (LoadLast || (r_count == LAST_ADDR)) begin
            w_state_next = RUN;
          end
        end
      end
      RUN: begin
        if (LoadStart) begin
          w_state_next = LOAD;
          w_count_next = '0;
        end else if (FetchReq) begin
          w_re = 1'b1;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Response qualifiers; the range flag is captured with the read so the
  // held InstOut keeps showing the same word until the next fetch.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_valid    <= 1'b0;
      r_in_range <= 1'b1;
    end else begin
      r_valid <= w_re;
      if (w_re) begin
        r_in_range <= ({1'b0, InstAddress} < r_count);
      end
    end
  end

  // Loads and fetches never overlap, so one address port serves both.
  assign w_addr = (r_state == LOAD) ? r_count[A-1:0] : InstAddress;

`ifdef INST_MEM_PARITY_EN
  assign w_wdata   = {(^LoadData) ^ ParityInject, LoadData};
  assign ParityErr = r_valid && r_in_range && (^w_rdata);
`else
  assign w_wdata   = LoadData;
  assign ParityErr = 1'b0;
`endif

  inst_mem_array #(
    .A  (A),
    .DW (DW)
  ) u_array (
    .i_clk   (Clk),
    .i_rst_n (Reset_n),
    .i_we    (w_we),
    .i_re    (w_re),
    .i_addr  (w_addr),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata)
  );

  assign LoadReady = (r_state == LOAD);
  assign LoadDone  = (r_state == RUN);
  assign LoadCount = r_count;
  assign InstValid = r_valid;
  assign InstOut   = r_in_range ? w_rdata[W-1:0] : HALT_WORD;

endmodule

// File: tb/tb_inst_mem.sv
// tb_inst_mem: directed table-driven bench for inst_mem (A=4, W=9) plus
// hand-written sequences for restart, full-array, reset and parity cases.
module tb_inst_mem;

  localparam int A = 4;
  localparam int W = 9;

  logic         Clk = 1'b0;
  logic         Reset_n;
  logic         LoadStart, LoadValid, LoadLast;
  logic [W-1:0] LoadData;
  logic         ParityInject;
  logic         LoadReady, LoadDone;
  logic [A:0]   LoadCount;
  logic         FetchReq;
  logic [A-1:0] InstAddress;
  logic [W-1:0] InstOut;
  logic         InstValid, ParityErr;

  int errors = 0;
  int checks = 0;

  inst_mem #(.A(A), .W(W)) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .LoadStart   (LoadStart),
    .LoadValid   (LoadValid),
    .LoadLast    (LoadLast),
    .LoadData    (LoadData),
`ifdef INST_MEM_PARITY_EN
    .ParityInject(ParityInject),
`endif
    .LoadReady   (LoadReady),
    .LoadDone    (LoadDone),
    .LoadCount   (LoadCount),
    .FetchReq    (FetchReq),
    .InstAddress (InstAddress),
    .InstOut     (InstOut),
    .InstValid   (InstValid),
    .ParityErr   (ParityErr)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic         start, valid, last;
    logic [W-1:0] data;
    logic         freq;
    logic [A-1:0] addr;
    logic         exp_ready, exp_done;
    logic [A:0]   exp_count;
    logic         exp_iv;
    logic [W-1:0] exp_inst;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic s, v, l, input logic [W-1:0] d,
                         input logic f, input logic [A-1:0] a,
                         input logic er, ed, input logic [A:0] ec,
                         input logic eiv, input logic [W-1:0] ei);
    vec_t t;
    t.start = s; t.valid = v; t.last = l; t.data = d; t.freq = f; t.addr = a;
    t.exp_ready = er; t.exp_done = ed; t.exp_count = ec;
    t.exp_iv = eiv; t.exp_inst = ei;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs are applied, one rising edge passes, outputs are sampled 1ns later.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic s, v, l, input logic [W-1:0] d,
                       input logic f, input logic [A-1:0] a);
    LoadStart = s; LoadValid = v; LoadLast = l; LoadData = d;
    FetchReq = f; InstAddress = a;
  endtask

  task automatic step(input string tag, input logic s, v, l, input logic [W-1:0] d,
                      input logic f, input logic [A-1:0] a);
    drive(s, v, l, d, f, a);
    tick();
    $display("%s: start=%0b valid=%0b last=%0b data=0x%03h freq=%0b addr=%0d -> ready=%0b done=%0b count=%0d iv=%0b inst=0x%03h perr=%0b",
             tag, s, v, l, d, f, a, LoadReady, LoadDone, LoadCount, InstValid, InstOut, ParityErr);
  endtask

  function automatic logic [W-1:0] full_word(input int i);
    return W'(i * 37 + 3);
  endfunction

  initial begin
    Reset_n = 1'b0;
    ParityInject = 1'b0;
    drive(0, 0, 0, '0, 0, '0);
    tick();
    tick();
    chk("rst.ready", LoadReady, 0);
    chk("rst.done",  LoadDone,  0);
    chk("rst.count", LoadCount, 0);
    chk("rst.iv",    InstValid, 0);
    chk("rst.inst",  InstOut,   0);
    chk("rst.perr",  ParityErr, 0);
    Reset_n = 1'b1;

    // Basic load of 4 words, fetches with 1-cycle latency, out-of-range HALT.
    //      st v  l  data    f  a   rdy dn cnt iv inst
    add_vec(1, 0, 0, 9'h000, 0, 0,  1,  0, 0,  0, 9'h000);
    add_vec(0, 1, 0, 9'h001, 0, 0,  1,  0, 1,  0, 9'h000);
    add_vec(0, 1, 0, 9'h049, 0, 0,  1,  0, 2,  0, 9'h000);
    add_vec(0, 1, 0, 9'h081, 0, 0,  1,  0, 3,  0, 9'h000);
    add_vec(0, 1, 1, 9'h1FF, 0, 0,  0,  1, 4,  0, 9'h000);
    add_vec(0, 0, 0, 9'h000, 1, 0,  0,  1, 4,  1, 9'h001);
    add_vec(0, 0, 0, 9'h000, 1, 1,  0,  1, 4,  1, 9'h049);
    add_vec(0, 0, 0, 9'h000, 1, 2,  0,  1, 4,  1, 9'h081);
    add_vec(0, 0, 0, 9'h000, 1, 3,  0,  1, 4,  1, 9'h1FF);
    add_vec(0, 0, 0, 9'h000, 1, 4,  0,  1, 4,  1, 9'h1FF);
    add_vec(0, 0, 0, 9'h000, 1, 5,  0,  1, 4,  1, 9'h1FF);
    add_vec(0, 0, 0, 9'h000, 0, 0,  0,  1, 4,  0, 9'h1FF);
    add_vec(0, 0, 0, 9'h000, 1, 2,  0,  1, 4,  1, 9'h081);
    add_vec(0, 0, 0, 9'h000, 0, 1,  0,  1, 4,  0, 9'h081);

    foreach (vecs[i]) begin
      step($sformatf("vec%0d", i), vecs[i].start, vecs[i].valid, vecs[i].last,
           vecs[i].data, vecs[i].freq, vecs[i].addr);
      chk($sformatf("vec%0d.ready", i), LoadReady, vecs[i].exp_ready);
      chk($sformatf("vec%0d.done", i),  LoadDone,  vecs[i].exp_done);
      chk($sformatf("vec%0d.count", i), LoadCount, vecs[i].exp_count);
      chk($sformatf("vec%0d.iv", i),    InstValid, vecs[i].exp_iv);
      chk($sformatf("vec%0d.inst", i),  InstOut,   vecs[i].exp_inst);
      chk($sformatf("vec%0d.perr", i),  ParityErr, 0);
    end

    // Restart from RUN with a coincident fetch: fetch dropped, count cleared.
    step("rs.start", 1, 0, 0, '0, 1, 0);
    chk("rs.start.ready", LoadReady, 1);
    chk("rs.start.done",  LoadDone,  0);
    chk("rs.start.count", LoadCount, 0);
    chk("rs.start.iv",    InstValid, 0);
    step("rs.w0",  0, 1, 0, 9'h0A0, 0, 0);
    step("rs.gap", 0, 0, 0, 9'h000, 0, 0);
    step("rs.w1",  0, 1, 0, 9'h0B0, 0, 0);
    chk("rs.w1.count", LoadCount, 2);
    step("rs.w2restart", 1, 1, 0, 9'h0C0, 0, 0);
    chk("rs.restart.count", LoadCount, 0);
    chk("rs.restart.ready", LoadReady, 1);
    step("rs.r0", 0, 1, 0, 9'h011, 0, 0);
    step("rs.gap2", 0, 0, 0, 9'h000, 0, 0);
    step("rs.r1", 0, 1, 1, 9'h022, 0, 0);
    chk("rs.r1.count", LoadCount, 2);
    chk("rs.r1.done",  LoadDone,  1);
    step("rs.f0", 0, 0, 0, '0, 1, 0);
    chk("rs.f0.inst", InstOut, 9'h011);
    step("rs.f1", 0, 0, 0, '0, 1, 1);
    chk("rs.f1.inst", InstOut, 9'h022);
    step("rs.f2", 0, 0, 0, '0, 1, 2);
    chk("rs.f2.iv",   InstValid, 1);
    chk("rs.f2.inst", InstOut, 9'h1FF);

    // Full-array load without LoadLast ends automatically after word 16.
    step("full.start", 1, 0, 0, '0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      step($sformatf("full.w%0d", i), 0, 1, 0, full_word(i), 0, 0);
      if (i == 14) begin
        chk("full.w14.count", LoadCount, 15);
        chk("full.w14.ready", LoadReady, 1);
      end
    end
    chk("full.count", LoadCount, 16);
    chk("full.done",  LoadDone,  1);
    chk("full.ready", LoadReady, 0);
    step("full.f15", 0, 0, 0, '0, 1, 15);
    chk("full.f15.inst", InstOut, full_word(15));
    step("full.f7", 0, 0, 0, '0, 1, 7);
    chk("full.f7.inst", InstOut, full_word(7));

    // Reset in the middle of a load returns every output to its reset value.
    step("mr.start", 1, 0, 0, '0, 0, 0);
    step("mr.w0", 0, 1, 0, 9'h101, 0, 0);
    step("mr.w1", 0, 1, 0, 9'h102, 0, 0);
    step("mr.w2", 0, 1, 0, 9'h103, 0, 0);
    Reset_n = 1'b0;
    step("mr.reset", 0, 1, 0, 9'h104, 1, 0);
    chk("mr.ready", LoadReady, 0);
    chk("mr.done",  LoadDone,  0);
    chk("mr.count", LoadCount, 0);
    chk("mr.iv",    InstValid, 0);
    chk("mr.inst",  InstOut,   0);
    chk("mr.perr",  ParityErr, 0);
    Reset_n = 1'b1;
    step("mr.idlefetch", 0, 0, 0, '0, 1, 0);
    chk("mr.idlefetch.iv", InstValid, 0);
    step("mr.start2", 1, 0, 0, '0, 0, 0);
    step("mr.l0", 0, 1, 1, 9'h055, 0, 0);
    chk("mr.l0.count", LoadCount, 1);
    step("mr.f0", 0, 0, 0, '0, 1, 0);
    chk("mr.f0.inst", InstOut, 9'h055);
    step("mr.f1", 0, 0, 0, '0, 1, 1);
    chk("mr.f1.inst", InstOut, 9'h1FF);

`ifdef INST_MEM_PARITY_EN
    // A corrupted parity bit is flagged but the word is still delivered.
    step("par.start", 1, 0, 0, '0, 0, 0);
    ParityInject = 1'b1;
    step("par.w0", 0, 1, 0, 9'h0AA, 0, 0);
    ParityInject = 1'b0;
    step("par.w1", 0, 1, 1, 9'h033, 0, 0);
    step("par.f0", 0, 0, 0, '0, 1, 0);
    chk("par.f0.inst", InstOut, 9'h0AA);
    chk("par.f0.perr", ParityErr, 1);
    step("par.f1", 0, 0, 0, '0, 1, 1);
    chk("par.f1.inst", InstOut, 9'h033);
    chk("par.f1.perr", ParityErr, 0);
    step("par.f5", 0, 0, 0, '0, 1, 5);
    chk("par.f5.inst", InstOut, 9'h1FF);
    chk("par.f5.perr", ParityErr, 0);
    step("par.idle", 0, 0, 0, '0, 0, 0);
    chk("par.idle.perr", ParityErr, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
